// File: rtl/barrel_shifter.sv
// barrel_shifter: registered left/right, logical/arithmetic barrel shifter.
// One clock of latency; a new operation can be accepted on every edge.
//
// Parameters:
//   ARCH  - 0: log2(WIDTH)-stage mux cascade
//           1: bit-reverse around a single right-shift core
//           2: behavioural shift operators
//   WIDTH - operand width, power of two, >= 2
//
// Ports:
//   CLK   in   clock, rising edge
//   RST   in   synchronous active-high reset (overrides EN)
//   EN    in   capture a result on this edge
//   LR    in   direction, 0 = left, 1 = right
//   LA    in   kind, 0 = logical, 1 = arithmetic (right shifts only)
//   RT    in   rotate instead of shift (only with BARREL_SHIFTER_ROTATE_EN)
//   W     in   shift amount, 0..WIDTH-1
//   A     in   operand
//   Y     out  registered result
//   VALID out  Y holds the result of the op captured on the previous edge
//
// Optional feature macro: BARREL_SHIFTER_ROTATE_EN adds the RT input.
module barrel_shifter #(
  parameter int ARCH  = 0,
  parameter int WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN,
  input  logic                     LR,
  input  logic                     LA,
`ifdef BARREL_SHIFTER_ROTATE_EN
  input  logic                     RT,
`endif
  input  logic [$clog2(WIDTH)-1:0] W,
  input  logic [WIDTH-1:0]         A,
  output logic [WIDTH-1:0]         Y,
  output logic                     VALID
);

  localparam int SW = $clog2(WIDTH);

  logic             rt;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] y_d, y_q;
  logic             valid_d, valid_q;

`ifdef BARREL_SHIFTER_ROTATE_EN
  assign rt = RT;
`else
  assign rt = 1'b0;
`endif

  if ((WIDTH < 2) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $error("barrel_shifter: WIDTH must be a power of two >= 2");
  end

  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] o;
    for (int i = 0; i < WIDTH; i++) o[i] = v[WIDTH-1-i];
    return o;
  endfunction

  // Shift amount used to build rotations from two plain shifts; W=0 gives
  // a shift by WIDTH, which yields zero and leaves the operand untouched.
  logic [SW:0] w_inv;
  assign w_inv = (SW+1)'(WIDTH) - {1'b0, W};

  if (ARCH == 0) begin : g_arch0
    logic [WIDTH-1:0] stg [SW+1];
    logic             fill_r;

    // Sign bit stays in place through every right-arithmetic stage, so the
    // original MSB is the fill for all of them.
    assign fill_r = LA & A[WIDTH-1];
    assign stg[0] = A;

    for (genvar k = 0; k < SW; k++) begin : g_stage
      localparam int S = 1 << k;
      logic [WIDTH-1:0] shr, shl;
      assign shr = rt ? {stg[k][S-1:0], stg[k][WIDTH-1:S]}
                      : {{S{fill_r}}, stg[k][WIDTH-1:S]};
      assign shl = rt ? {stg[k][WIDTH-S-1:0], stg[k][WIDTH-1:WIDTH-S]}
                      : {stg[k][WIDTH-S-1:0], {S{1'b0}}};
      assign stg[k+1] = !W[k] ? stg[k] : (LR ? shr : shl);
    end

    assign r = stg[SW];
  end else if (ARCH == 1) begin : g_arch1
    logic [WIDTH-1:0] core_in, core_out, sr, rot;
    logic             fill;

    // Left ops become right ops on the reversed operand.
    assign core_in  = LR ? A : rev(A);
    assign fill     = LR & LA & A[WIDTH-1];
    assign sr       = (core_in >> W) | (~({WIDTH{1'b1}} >> W) & {WIDTH{fill}});
    assign rot      = (core_in >> W) | (core_in << w_inv);
    assign core_out = rt ? rot : sr;
    assign r        = LR ? core_out : rev(core_out);
  end else if (ARCH == 2) begin : g_arch2
    logic [WIDTH-1:0] sra, srl, sll, rotr, rotl;

    // Kept as its own assignment so the signed context of >>> is preserved.
    assign sra  = $unsigned($signed(A) >>> W);
    assign srl  = A >> W;
    assign sll  = A << W;
    assign rotr = (A >> W) | (A << w_inv);
    assign rotl = (A << W) | (A >> w_inv);
    assign r    = rt ? (LR ? rotr : rotl)
                     : (LR ? (LA ? sra : srl) : sll);
  end else begin : g_bad_arch
    $error("barrel_shifter: ARCH must be 0, 1 or 2");
  end

  always_comb begin
    y_d     = y_q;
    valid_d = 1'b0;
    if (EN) begin
      y_d     = r;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign Y     = y_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_barrel_shifter.sv
// Scoreboard bench for barrel_shifter: the three architectures run side by
// side on identical stimulus; each edge pushes the expected {VALID, Y} and a
// monitor on the falling edge pops and compares all three instances.
module tb_barrel_shifter;

  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1, en = 1'b0, lr = 1'b0, la = 1'b0, rt = 1'b0;
  logic [4:0]  w = '0;
  logic [31:0] a = '0;
  logic [31:0] y0, y1, y2;
  logic        v0, v1, v2;

  always #5 clk = ~clk;

  barrel_shifter #(.ARCH(0), .WIDTH(WIDTH)) u_a0 (
    .CLK(clk), .RST(rst), .EN(en), .LR(lr), .LA(la),
`ifdef BARREL_SHIFTER_ROTATE_EN
    .RT(rt),
`endif
    .W(w), .A(a), .Y(y0), .VALID(v0));

  barrel_shifter #(.ARCH(1), .WIDTH(WIDTH)) u_a1 (
    .CLK(clk), .RST(rst), .EN(en), .LR(lr), .LA(la),
`ifdef BARREL_SHIFTER_ROTATE_EN
    .RT(rt),
`endif
    .W(w), .A(a), .Y(y1), .VALID(v1));

  barrel_shifter #(.ARCH(2), .WIDTH(WIDTH)) u_a2 (
    .CLK(clk), .RST(rst), .EN(en), .LR(lr), .LA(la),
`ifdef BARREL_SHIFTER_ROTATE_EN
    .RT(rt),
`endif
    .W(w), .A(a), .Y(y2), .VALID(v2));

  typedef struct {
    logic        v;
    logic [31:0] y;
    string       nm;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] held_y = '0;

  // Bit-by-bit reference: each result bit looks up its source bit in A.
  function automatic logic [31:0] model(input logic m_lr, input logic m_la,
                                        input logic m_rt, input logic [4:0] m_w,
                                        input logic [31:0] m_a);
    logic [31:0] o;
    int src;
    for (int i = 0; i < 32; i++) begin
      if (m_lr) begin
        src = i + int'(m_w);
        if (src < 32)  o[i] = m_a[src];
        else if (m_rt) o[i] = m_a[src-32];
        else           o[i] = m_la & m_a[31];
      end else begin
        src = i - int'(m_w);
        if (src >= 0)  o[i] = m_a[src];
        else if (m_rt) o[i] = m_a[src+32];
        else           o[i] = 1'b0;
      end
    end
    return o;
  endfunction

  task automatic step(input logic s_rst, input logic s_en, input logic s_lr,
                      input logic s_la, input logic s_rt, input logic [4:0] s_w,
                      input logic [31:0] s_a, input logic [31:0] s_exp,
                      input string nm);
    exp_t e;
    @(negedge clk);
    rst = s_rst; en = s_en; lr = s_lr; la = s_la; rt = s_rt; w = s_w; a = s_a;
    @(posedge clk);
    e.nm = nm;
    if (s_rst) begin
      e.v = 1'b0; e.y = '0; held_y = '0;
    end else if (s_en) begin
      e.v = 1'b1; e.y = s_exp; held_y = s_exp;
    end else begin
      e.v = 1'b0; e.y = held_y;
    end
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] yy;
    logic        vv;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        for (int k = 0; k < 3; k++) begin
          case (k)
            0:       begin yy = y0; vv = v0; end
            1:       begin yy = y1; vv = v1; end
            default: begin yy = y2; vv = v2; end
          endcase
          checks++;
          if (vv !== e.v || yy !== e.y) begin
            failures++;
            $display("FAIL %s arch%0d: got VALID=%b Y=%08h, want VALID=%b Y=%08h",
                     e.nm, k, vv, yy, e.v, e.y);
          end
        end
      end
    end
  end

  initial begin : stim
    logic        r_lr, r_la, r_rt;
    logic [4:0]  r_w;
    logic [31:0] r_a;

    step(1, 1, 1, 1, 0, 5'd7, 32'hFFFF_FFFF, 32'h0, "reset0");
    step(1, 1, 0, 0, 0, 5'd3, 32'h1234_5678, 32'h0, "reset1");
    step(0, 0, 0, 0, 0, 5'd3, 32'h1234_5678, 32'h0, "release_idle");

    step(0, 1, 0, 0, 0, 5'd4, 32'h8000_0001, 32'h0000_0010, "sll4");
    step(0, 1, 0, 1, 0, 5'd4, 32'h8000_0001, 32'h0000_0010, "sla4");
    step(0, 1, 1, 0, 0, 5'd4, 32'h8000_0001, 32'h0800_0000, "srl4");
    step(0, 1, 1, 1, 0, 5'd4, 32'h8000_0001, 32'hF800_0000, "sra4");

    step(0, 1, 0, 0, 0, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "w0_ll");
    step(0, 1, 0, 1, 0, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "w0_la");
    step(0, 1, 1, 0, 0, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "w0_rl");
    step(0, 1, 1, 1, 0, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "w0_ra");

    step(0, 1, 1, 1, 0, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, "w31_sra");
    step(0, 1, 1, 0, 0, 5'd31, 32'h8000_0000, 32'h0000_0001, "w31_srl");
    step(0, 1, 0, 0, 0, 5'd31, 32'h0000_0001, 32'h8000_0000, "w31_sll");
    step(0, 1, 1, 1, 0, 5'd8,  32'h7F00_0000, 32'h007F_0000, "sra_pos");

    step(0, 0, 1, 0, 0, 5'd1, 32'h0000_00FF, 32'h0, "hold0");
    step(0, 0, 0, 1, 0, 5'd9, 32'hAAAA_5555, 32'h0, "hold1");
    step(0, 1, 0, 0, 0, 5'd1, 32'h0000_0003, 32'h0000_0006, "pre_rst");
    step(1, 1, 0, 0, 0, 5'd2, 32'h0000_0003, 32'h0, "rst_over_en");
    step(0, 0, 0, 0, 0, 5'd2, 32'h0000_0003, 32'h0, "post_rst_idle");
    step(0, 1, 1, 0, 0, 5'd16, 32'hCAFE_0000, 32'h0000_CAFE, "first_after_rst");

`ifdef BARREL_SHIFTER_ROTATE_EN
    step(0, 1, 1, 0, 1, 5'd4, 32'h8000_0001, 32'h1800_0000, "rotr_l");
    step(0, 1, 1, 1, 1, 5'd4, 32'h8000_0001, 32'h1800_0000, "rotr_a");
    step(0, 1, 0, 0, 1, 5'd4, 32'h8000_0001, 32'h0000_0018, "rotl_l");
    step(0, 1, 0, 1, 1, 5'd4, 32'h8000_0001, 32'h0000_0018, "rotl_a");
    step(0, 1, 1, 0, 1, 5'd0, 32'h1234_5678, 32'h1234_5678, "rot_w0");
`endif

    for (int i = 0; i < 400; i++) begin
      r_lr = 1'($urandom);
      r_la = 1'($urandom);
`ifdef BARREL_SHIFTER_ROTATE_EN
      r_rt = 1'($urandom);
`else
      r_rt = 1'b0;
`endif
      r_w  = 5'($urandom);
      r_a  = $urandom;
      step(0, 1, r_lr, r_la, r_rt, r_w, r_a, model(r_lr, r_la, r_rt, r_w, r_a), "random");
    end

    step(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, "final_hold");

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d entries left, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
